operand_fetch_ctrl: RTL and testbench

OPERAND_FETCH_CTRL -- requirements
Module: operand_fetch_ctrl

---
 rtl/cpu6502_pkg.sv | 34 +++
 rtl/operand_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_operand_fetch_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu6502_pkg.sv
// Shared 6502 core definitions: addressing modes and the operand-fetch
// sequencer state encoding.
package cpu6502_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_ZP   = 2'd1,
    MODE_ABS  = 2'd2,
    MODE_IND  = 2'd3
  } mode_e;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_L  = 4'd1,
    S_SU_L  = 4'd2,
    S_ST_L  = 4'd3,
    S_RD_H  = 4'd4,
    S_SU_H  = 4'd5,
    S_ST_H  = 4'd6,
    S_RD_IL = 4'd7,
    S_INC   = 4'd8,
    S_RD_IH = 4'd9,
    S_SU_IH = 4'd10,
    S_ST_IH = 4'd11,
    S_SU_IL = 4'd12,
    S_ST_IL = 4'd13,
    S_FIN   = 4'd14
  } ofc_state_e;

  function automatic logic is_rd_state(input ofc_state_e s);
    return (s == S_RD_L) || (s == S_RD_H) || (s == S_RD_IL) || (s == S_RD_IH);
  endfunction

endpackage

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: reads the 1/2-byte operand (and the indirect
// pointer target) and drives the external 16-bit address latch strobes.
module operand_fetch_ctrl
  import cpu6502_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] mem_data,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       addr_sel,
  output logic       pc_inc,
  output logic [7:0] lat_d,
  output logic       latch_l,
  output logic       latch_h,
  output logic       latch_inc,
  output logic       busy,
  output logic       done
);

  ofc_state_e state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [7:0] lat_d_q, lat_d_d;
  logic [7:0] hold_q, hold_d;
  logic       mem_rd_q, mem_rd_d;
  logic       addr_sel_q, addr_sel_d;
  logic       pc_inc_q, pc_inc_d;
  logic       latch_l_q, latch_l_d;
  logic       latch_h_q, latch_h_d;
  logic       latch_inc_q, latch_inc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lat_d_d = lat_d_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (mode != MODE_NONE)) begin
          state_d = S_RD_L;
          mode_d  = mode_e'(mode);
        end
      end
      S_RD_L: begin
        if (mem_ack) begin
          state_d = S_SU_L;
          lat_d_d = mem_data;
        end
      end
      S_SU_L: state_d = S_ST_L;
      S_ST_L: begin
        // Zero page skips the high-byte read and forces page 00.
        if (mode_q == MODE_ZP) begin
          state_d = S_SU_H;
          lat_d_d = 8'h00;
        end else begin
          state_d = S_RD_H;
        end
      end
      S_RD_H: begin
        if (mem_ack) begin
          state_d = S_SU_H;
          lat_d_d = mem_data;
        end
      end
      S_SU_H: state_d = S_ST_H;
      S_ST_H: state_d = (mode_q == MODE_IND) ? S_RD_IL : S_FIN;
      S_RD_IL: begin
        // Target low byte is parked until the high half has been loaded,
        // since the latch still holds the pointer for the second read.
        if (mem_ack) begin
          state_d = S_INC;
          hold_d  = mem_data;
        end
      end
      S_INC: state_d = S_RD_IH;
      S_RD_IH: begin
        if (mem_ack) begin
          state_d = S_SU_IH;
          lat_d_d = mem_data;
        end
      end
      S_SU_IH: state_d = S_ST_IH;
      S_ST_IH: begin
        state_d = S_SU_IL;
        lat_d_d = hold_q;
      end
      S_SU_IL: state_d = S_ST_IL;
      S_ST_IL: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave a flop aligned
  // with the state they belong to.
  always_comb begin
    mem_rd_d    = is_rd_state(state_d);
    addr_sel_d  = (state_d == S_RD_IL) || (state_d == S_RD_IH);
    pc_inc_d    = (state_d == S_SU_L) ||
                  ((state_d == S_SU_H) && (mode_d != MODE_ZP));
    latch_l_d   = (state_d == S_ST_L) || (state_d == S_ST_IL);
    latch_h_d   = (state_d == S_ST_H) || (state_d == S_ST_IH);
    latch_inc_d = (state_d == S_INC);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_NONE;
      lat_d_q     <= 8'h00;
      hold_q      <= 8'h00;
      mem_rd_q    <= 1'b0;
      addr_sel_q  <= 1'b0;
      pc_inc_q    <= 1'b0;
      latch_l_q   <= 1'b0;
      latch_h_q   <= 1'b0;
      latch_inc_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      lat_d_q     <= lat_d_d;
      hold_q      <= hold_d;
      mem_rd_q    <= mem_rd_d;
      addr_sel_q  <= addr_sel_d;
      pc_inc_q    <= pc_inc_d;
      latch_l_q   <= latch_l_d;
      latch_h_q   <= latch_h_d;
      latch_inc_q <= latch_inc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign addr_sel  = addr_sel_q;
  assign pc_inc    = pc_inc_q;
  assign lat_d     = lat_d_q;
  assign latch_l   = latch_l_q;
  assign latch_h   = latch_h_q;
  assign latch_inc = latch_inc_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed bench for operand_fetch_ctrl with a PC, address-latch and memory
// model wrapped around the sequencer.
module tb_operand_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] mem_data;
  logic       mem_ack;
  logic       mem_rd, addr_sel, pc_inc, latch_l, latch_h, latch_inc, busy, done;
  logic [7:0] lat_d;

  logic [7:0]  mem [0:65535];
  logic [15:0] pc_m, latch_m, addr;
  int          stall, wait_cnt;
  int          checks, errors;

  int          done_cyc, n_pc, n_ll, n_lh, n_li, n_rd, n_ovl, n_ind, ll_cyc, lh_cyc;
  logic [7:0]  ll_dat, lh_dat;
  logic [15:0] ind_addr [2];
  logic        post_busy, li_at_rst, rst_zero;

  operand_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .mem_data(mem_data), .mem_ack(mem_ack), .mem_rd(mem_rd),
    .addr_sel(addr_sel), .pc_inc(pc_inc), .lat_d(lat_d),
    .latch_l(latch_l), .latch_h(latch_h), .latch_inc(latch_inc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign addr     = addr_sel ? latch_m : pc_m;
  assign mem_data = mem[addr];
  assign mem_ack  = mem_rd && (wait_cnt >= stall);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wait_cnt <= 0;
    else if (mem_rd && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  // Runs one operation; start is re-pulsed and mode scrambled while busy.
  task automatic run_op(input logic [1:0] m, input int reset_at);
    done_cyc = -1; n_pc = 0; n_ll = 0; n_lh = 0; n_li = 0; n_rd = 0;
    n_ovl = 0; n_ind = 0; ll_cyc = -1; lh_cyc = -1; ll_dat = 8'hxx;
    lh_dat = 8'hxx; post_busy = 1'b1; li_at_rst = 1'b0; rst_zero = 1'b0;
    ind_addr[0] = 16'h0000; ind_addr[1] = 16'h0000;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = (c == 2);
      mode  = m ^ 2'b11;
      if (mem_rd) n_rd++;
      if (pc_inc) n_pc++;
      if (latch_l) begin n_ll++; ll_cyc = c; ll_dat = lat_d; end
      if (latch_h) begin n_lh++; lh_cyc = c; lh_dat = lat_d; end
      if (latch_inc) n_li++;
      if ((int'(latch_l) + int'(latch_h) + int'(latch_inc)) > 1) n_ovl++;
      if (mem_rd && mem_ack && addr_sel) begin
        if (n_ind < 2) ind_addr[n_ind] = addr;
        n_ind++;
      end
      if (c == reset_at) begin
        li_at_rst = latch_inc;
        rst_n = 1'b0;
        #1;
        rst_zero = ({mem_rd, addr_sel, pc_inc, latch_l, latch_h, latch_inc,
                     busy, done} == 8'h00) && (lat_d == 8'h00);
        break;
      end
      if (pc_inc) pc_m = pc_m + 16'd1;
      if (latch_l) latch_m[7:0] = lat_d;
      if (latch_h) latch_m[15:8] = lat_d;
      if (latch_inc) latch_m = latch_m + 16'd1;
      if (done) begin
        done_cyc = c;
        start = 1'b0;
        @(negedge clk);
        post_busy = busy;
        break;
      end
    end
    start = 1'b0;
    mode  = 2'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; mode = 2'd0; stall = 0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %0b want 0", mem_rd); end
    checks++; if (addr_sel !== 1'b0) begin errors++; $display("FAIL reset_addr_sel got %0b want 0", addr_sel); end
    checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL reset_pc_inc got %0b want 0", pc_inc); end
    checks++; if (latch_l !== 1'b0) begin errors++; $display("FAIL reset_latch_l got %0b want 0", latch_l); end
    checks++; if (latch_h !== 1'b0) begin errors++; $display("FAIL reset_latch_h got %0b want 0", latch_h); end
    checks++; if (latch_inc !== 1'b0) begin errors++; $display("FAIL reset_latch_inc got %0b want 0", latch_inc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (lat_d !== 8'h00) begin errors++; $display("FAIL reset_lat_d got %h want 00", lat_d); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zp();
    pc_m = 16'h0200; latch_m = 16'hFFFF; mem[16'h0200] = 8'h80; stall = 0;
    run_op(2'd1, 0);
    checks++; if (done_cyc != 6) begin errors++; $display("FAIL zp_done_cycle got %0d want 6", done_cyc); end
    checks++; if (n_pc != 1) begin errors++; $display("FAIL zp_pc_inc_count got %0d want 1", n_pc); end
    checks++; if (lh_dat !== 8'h00) begin errors++; $display("FAIL zp_latch_h_data got %h want 00", lh_dat); end
    checks++; if (latch_m !== 16'h0080) begin errors++; $display("FAIL zp_latch got %h want 0080", latch_m); end
    checks++; if (n_rd != 1) begin errors++; $display("FAIL zp_read_cycles got %0d want 1", n_rd); end
    checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL zp_idle_after got %0b want 0", post_busy); end
  endtask

  task automatic test_abs();
    pc_m = 16'h0300; latch_m = 16'h0000; stall = 0;
    mem[16'h0300] = 8'h34; mem[16'h0301] = 8'h12;
    run_op(2'd2, 0);
    checks++; if (ll_cyc != 3 || ll_dat !== 8'h34) begin errors++; $display("FAIL abs_latch_l got cyc %0d data %h want cyc 3 data 34", ll_cyc, ll_dat); end
    checks++; if (lh_cyc != 6 || lh_dat !== 8'h12) begin errors++; $display("FAIL abs_latch_h got cyc %0d data %h want cyc 6 data 12", lh_cyc, lh_dat); end
    checks++; if (n_pc != 2) begin errors++; $display("FAIL abs_pc_inc_count got %0d want 2", n_pc); end
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL abs_done_cycle got %0d want 7", done_cyc); end
    checks++; if (latch_m !== 16'h1234) begin errors++; $display("FAIL abs_latch got %h want 1234", latch_m); end
    checks++; if (n_ll != 1 || n_lh != 1 || n_li != 0) begin errors++; $display("FAIL abs_strobe_counts got %0d/%0d/%0d want 1/1/0", n_ll, n_lh, n_li); end
    checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL abs_idle_after got %0b want 0", post_busy); end
  endtask

  task automatic test_ind();
    pc_m = 16'h0400; latch_m = 16'h0000; stall = 0;
    mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h10;
    mem[16'h10FF] = 8'hCD; mem[16'h1100] = 8'hAB;
    run_op(2'd3, 0);
    checks++; if (ind_addr[0] !== 16'h10FF) begin errors++; $display("FAIL ind_rd_il_addr got %h want 10FF", ind_addr[0]); end
    checks++; if (ind_addr[1] !== 16'h1100) begin errors++; $display("FAIL ind_rd_ih_addr got %h want 1100", ind_addr[1]); end
    checks++; if (n_li != 1) begin errors++; $display("FAIL ind_latch_inc_count got %0d want 1", n_li); end
    checks++; if (latch_m !== 16'hABCD) begin errors++; $display("FAIL ind_latch got %h want ABCD", latch_m); end
    checks++; if (done_cyc != 14) begin errors++; $display("FAIL ind_done_cycle got %0d want 14", done_cyc); end
    checks++; if (n_ll != 2 || n_lh != 2 || n_pc != 2) begin errors++; $display("FAIL ind_strobe_counts got ll %0d lh %0d pc %0d want 2/2/2", n_ll, n_lh, n_pc); end
    checks++; if (n_ovl != 0) begin errors++; $display("FAIL ind_strobe_overlap got %0d want 0", n_ovl); end
  endtask

  task automatic test_stall();
    pc_m = 16'h0600; latch_m = 16'h0000; stall = 3;
    mem[16'h0600] = 8'h9A; mem[16'h0601] = 8'h5E;
    run_op(2'd2, 0);
    stall = 0;
    checks++; if (done_cyc != 13) begin errors++; $display("FAIL stall_done_cycle got %0d want 13", done_cyc); end
    checks++; if (n_rd != 8) begin errors++; $display("FAIL stall_mem_rd_cycles got %0d want 8", n_rd); end
    checks++; if (ll_cyc != 6 || lh_cyc != 12) begin errors++; $display("FAIL stall_strobe_cycles got %0d/%0d want 6/12", ll_cyc, lh_cyc); end
    checks++; if (n_ll != 1 || n_lh != 1 || n_li != 0 || n_pc != 2) begin errors++; $display("FAIL stall_strobe_counts got %0d/%0d/%0d/%0d want 1/1/0/2", n_ll, n_lh, n_li, n_pc); end
    checks++; if (latch_m !== 16'h5E9A) begin errors++; $display("FAIL stall_latch got %h want 5E9A", latch_m); end
  endtask

  task automatic test_reset_mid();
    pc_m = 16'h0400; latch_m = 16'h0000; stall = 0;
    run_op(2'd3, 8);
    checks++; if (li_at_rst !== 1'b1) begin errors++; $display("FAIL midrst_in_inc got %0b want 1", li_at_rst); end
    checks++; if (rst_zero !== 1'b1) begin errors++; $display("FAIL midrst_outputs_zero got %0b want 1", rst_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pc_m = 16'h0500;
    mem[16'h0500] = 8'h78; mem[16'h0501] = 8'h56;
    run_op(2'd2, 0);
    checks++; if (done_cyc != 7) begin errors++; $display("FAIL midrst_abs_done got %0d want 7", done_cyc); end
    checks++; if (latch_m !== 16'h5678) begin errors++; $display("FAIL midrst_abs_latch got %h want 5678", latch_m); end
  endtask

  task automatic test_ignore();
    int events;
    events = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (busy || done || mem_rd || pc_inc || latch_l || latch_h || latch_inc) events++;
    end
    checks++; if (events != 0) begin errors++; $display("FAIL ignore_mode0 got %0d active cycles want 0", events); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_zp();
    test_abs();
    test_ind();
    test_stall();
    test_reset_mid();
    test_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
